// File: rtl/ntt_ctrl_if.sv
// Handshake and datapath-control bundle between the ML-DSA sequencer, ntt_ctrl,
// the BFU, the coefficient RAM and the zeta ROM.
interface ntt_ctrl_if #(
   parameter int unsigned LOGN = 8
);
   logic            i_start;
   logic            i_intt;
   logic            o_busy;
   logic            o_done;
   logic            o_rd_en;
   logic [LOGN-1:0] o_rd_addr_a;
   logic [LOGN-1:0] o_rd_addr_b;
   logic [LOGN-1:0] o_tw_idx;
   logic            o_tw_neg;
   logic            o_bfu_intt;
   logic            o_bfu_skip;
   logic            o_wr_en;
   logic [LOGN-1:0] o_wr_addr_a;
   logic [LOGN-1:0] o_wr_addr_b;

   modport master (
      output i_start, i_intt,
      input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx, o_tw_neg,
             o_bfu_intt, o_bfu_skip, o_wr_en, o_wr_addr_a, o_wr_addr_b
   );

   modport slave (
      input  i_start, i_intt,
      output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx, o_tw_neg,
             o_bfu_intt, o_bfu_skip, o_wr_en, o_wr_addr_a, o_wr_addr_b
   );
endinterface

// File: rtl/ntt_ctrl.sv
// Sequences one forward/inverse NTT through a single BFU: one butterfly read per cycle,
// twiddle index generation and delay-matched write-back addresses.
module ntt_ctrl #(
   parameter int unsigned N          = 256,
   parameter int unsigned LOGN       = $clog2(N),
   parameter int unsigned MEM_RD_LAT = 1,
   parameter int unsigned BFU_LAT    = 4
) (
   input logic       i_clk,
   input logic       i_rst,
   ntt_ctrl_if.slave bus
);

   localparam int unsigned L  = MEM_RD_LAT + BFU_LAT;
   localparam int unsigned LW = $clog2(LOGN);

   localparam logic [LOGN-1:0] CntLast   = LOGN'(N / 2 - 1);
   localparam logic [LOGN-1:0] DrainLast = LOGN'(L - 1);
   localparam logic [LW-1:0]   LayerLast = LW'(LOGN - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [LOGN-1:0] cnt_q, cnt_d;
   logic [LW-1:0]   layer_q, layer_d;
   logic            intt_q, intt_d;

   logic            rd_en;
   logic [LOGN-1:0] rd_a, rd_b;

   logic [L-1:0]    dly_en_q;
   logic [LOGN-1:0] dly_a_q [L];
   logic [LOGN-1:0] dly_b_q [L];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         layer_q  <= '0;
         intt_q   <= 1'b0;
         dly_en_q <= '0;
         for (int i = 0; i < L; i++) begin
            dly_a_q[i] <= '0;
            dly_b_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         layer_q     <= layer_d;
         intt_q      <= intt_d;
         // Write-back line keeps shifting through DRAIN so every read yields one write.
         dly_en_q[0] <= rd_en;
         dly_a_q[0]  <= rd_a;
         dly_b_q[0]  <= rd_b;
         for (int i = 1; i < L; i++) begin
            dly_en_q[i] <= dly_en_q[i-1];
            dly_a_q[i]  <= dly_a_q[i-1];
            dly_b_q[i]  <= dly_b_q[i-1];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      layer_d = layer_q;
      intt_d  = intt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.i_start) begin
               intt_d  = bus.i_intt;
               layer_d = '0;
               cnt_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + LOGN'(1);
            end
         end
         StDrain: begin
            // Hold off the next layer until the last write of this one has landed.
            if (cnt_q == DrainLast) begin
               cnt_d = '0;
               if (layer_q == LayerLast) begin
                  state_d = StDone;
               end else begin
                  layer_d = layer_q + LW'(1);
                  state_d = StIssue;
               end
            end else begin
               cnt_d = cnt_q + LOGN'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   logic [LW-1:0]   s;
   logic [LOGN-1:0] len, g, j, tw;

   always_comb begin
      rd_en = (state_q == StIssue);
      s     = intt_q ? layer_q : (LayerLast - layer_q);
      len   = LOGN'(1) << s;
      g     = cnt_q >> s;
      j     = ((g << 1) << s) | (cnt_q & (len - LOGN'(1)));
      // (N >> s) - 1 == all-ones >> s, avoiding a LOGN+1 bit intermediate.
      tw    = intt_q ? (({LOGN{1'b1}} >> s) - g) : ((LOGN'(1) << layer_q) + g);
      rd_a  = rd_en ? j : '0;
      rd_b  = rd_en ? (j + len) : '0;

      bus.o_busy      = (state_q == StIssue) || (state_q == StDrain);
      bus.o_done      = (state_q == StDone);
      bus.o_rd_en     = rd_en;
      bus.o_rd_addr_a = rd_a;
      bus.o_rd_addr_b = rd_b;
      bus.o_tw_idx    = rd_en ? tw : '0;
      bus.o_tw_neg    = intt_q;
      bus.o_bfu_intt  = intt_q;
      bus.o_bfu_skip  = 1'b0;
      bus.o_wr_en     = dly_en_q[L-1];
      bus.o_wr_addr_a = dly_a_q[L-1];
      bus.o_wr_addr_b = dly_b_q[L-1];
   end

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: address/twiddle spot checks, write alignment, latency,
// start/mode immunity while busy, back-to-back start and mid-op reset.
module tb_ntt_ctrl;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   int   cyc;
   int   wr_cnt;

   ntt_ctrl_if #(.LOGN(8)) bus ();

   ntt_ctrl #(
      .N          (256),
      .LOGN       (8),
      .MEM_RD_LAT (1),
      .BFU_LAT    (4)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] tw);
      check({tag, " rd_en"}, 32'(bus.o_rd_en), 32'd1);
      check({tag, " rd_a"}, 32'(bus.o_rd_addr_a), a);
      check({tag, " rd_b"}, 32'(bus.o_rd_addr_b), b);
      check({tag, " tw"}, 32'(bus.o_tw_idx), tw);
   endtask

   task automatic check_wr(input string tag, input logic [31:0] a, input logic [31:0] b);
      check({tag, " wr_en"}, 32'(bus.o_wr_en), 32'd1);
      check({tag, " wr_a"}, 32'(bus.o_wr_addr_a), a);
      check({tag, " wr_b"}, 32'(bus.o_wr_addr_b), b);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " busy"}, 32'(bus.o_busy), 32'd0);
      check({tag, " done"}, 32'(bus.o_done), 32'd0);
      check({tag, " rd_en"}, 32'(bus.o_rd_en), 32'd0);
      check({tag, " rd_a"}, 32'(bus.o_rd_addr_a), 32'd0);
      check({tag, " rd_b"}, 32'(bus.o_rd_addr_b), 32'd0);
      check({tag, " tw"}, 32'(bus.o_tw_idx), 32'd0);
      check({tag, " tw_neg"}, 32'(bus.o_tw_neg), 32'd0);
      check({tag, " bfu_intt"}, 32'(bus.o_bfu_intt), 32'd0);
      check({tag, " bfu_skip"}, 32'(bus.o_bfu_skip), 32'd0);
      check({tag, " wr_en"}, 32'(bus.o_wr_en), 32'd0);
      check({tag, " wr_a"}, 32'(bus.o_wr_addr_a), 32'd0);
      check({tag, " wr_b"}, 32'(bus.o_wr_addr_b), 32'd0);
   endtask

   // Sample 1 time unit after each rising edge; cyc counts cycles since the start cycle.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_wr_en === 1'b1) wr_cnt++;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      cyc         = 0;
      wr_cnt      = 0;
      rst         = 1'b1;
      bus.i_start = 1'b0;
      bus.i_intt  = 1'b0;
      #12;
      check_idle_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      check_idle_outputs("idle");

      // Forward NTT, with stray start/intt pulses at cycles 10 and 500.
      cyc         = 0;
      wr_cnt      = 0;
      bus.i_start = 1'b1;
      bus.i_intt  = 1'b0;
      check("ntt c0 busy", 32'(bus.o_busy), 32'd0);
      step();
      bus.i_start = 1'b0;
      check("ntt c1 busy", 32'(bus.o_busy), 32'd1);
      check("ntt c1 neg", 32'(bus.o_tw_neg), 32'd0);
      check_rd("ntt l0c0", 32'd0, 32'd128, 32'd1);
      run_to(5);
      check("ntt c5 wr_en", 32'(bus.o_wr_en), 32'd0);
      run_to(6);
      check_wr("ntt wr l0c0", 32'd0, 32'd128);
      run_to(10);
      bus.i_start = 1'b1;
      bus.i_intt  = 1'b1;
      step();
      bus.i_start = 1'b0;
      bus.i_intt  = 1'b0;
      run_to(128);
      check_rd("ntt l0c127", 32'd127, 32'd255, 32'd1);
      run_to(129);
      check("ntt drain rd_en", 32'(bus.o_rd_en), 32'd0);
      check("ntt drain busy", 32'(bus.o_busy), 32'd1);
      run_to(133);
      check_wr("ntt wr l0 last", 32'd127, 32'd255);
      check("ntt l0 last rd_en", 32'(bus.o_rd_en), 32'd0);
      run_to(134);
      check("ntt l1 first wr_en", 32'(bus.o_wr_en), 32'd0);
      check_rd("ntt l1c0", 32'd0, 32'd64, 32'd2);
      check("ntt writes per layer", 32'(wr_cnt), 32'd128);
      run_to(198);
      check_rd("ntt l1c64", 32'd128, 32'd192, 32'd3);
      run_to(203);
      check_wr("ntt wr l1c64", 32'd128, 32'd192);
      run_to(500);
      bus.i_start = 1'b1;
      bus.i_intt  = 1'b1;
      step();
      bus.i_start = 1'b0;
      bus.i_intt  = 1'b0;
      check("ntt after pulse neg", 32'(bus.o_tw_neg), 32'd0);
      check("ntt after pulse busy", 32'(bus.o_busy), 32'd1);
      run_to(932);
      check_rd("ntt l7c0", 32'd0, 32'd1, 32'd128);
      run_to(1059);
      check_rd("ntt l7c127", 32'd254, 32'd255, 32'd255);
      run_to(1064);
      check_wr("ntt wr last", 32'd254, 32'd255);
      check("ntt c1064 done", 32'(bus.o_done), 32'd0);
      check("ntt c1064 busy", 32'(bus.o_busy), 32'd1);
      run_to(1065);
      check("ntt done", 32'(bus.o_done), 32'd1);
      check("ntt done busy", 32'(bus.o_busy), 32'd0);
      check("ntt write count", 32'(wr_cnt), 32'd1024);
      run_to(1066);
      check("ntt done pulse", 32'(bus.o_done), 32'd0);

      // Inverse NTT with i_start held high throughout; i_intt dropped mid-op.
      cyc         = 0;
      wr_cnt      = 0;
      bus.i_start = 1'b1;
      bus.i_intt  = 1'b1;
      step();
      check_rd("intt l0c0", 32'd0, 32'd1, 32'd255);
      check("intt neg", 32'(bus.o_tw_neg), 32'd1);
      check("intt bfu_intt", 32'(bus.o_bfu_intt), 32'd1);
      run_to(2);
      check_rd("intt l0c1", 32'd2, 32'd3, 32'd254);
      run_to(50);
      bus.i_intt = 1'b0;
      run_to(134);
      check_rd("intt l1c0", 32'd0, 32'd2, 32'd127);
      run_to(932);
      check_rd("intt l7c0", 32'd0, 32'd128, 32'd1);
      check("intt l7 neg", 32'(bus.o_tw_neg), 32'd1);
      check("intt l7 bfu_intt", 32'(bus.o_bfu_intt), 32'd1);
      check("intt skip", 32'(bus.o_bfu_skip), 32'd0);
      run_to(1065);
      check("intt done", 32'(bus.o_done), 32'd1);
      check("intt write count", 32'(wr_cnt), 32'd1024);
      run_to(1066);
      check("b2b idle busy", 32'(bus.o_busy), 32'd0);
      run_to(1067);
      check("b2b busy", 32'(bus.o_busy), 32'd1);
      check("b2b neg", 32'(bus.o_tw_neg), 32'd0);
      check_rd("b2b l0c0", 32'd0, 32'd128, 32'd1);
      bus.i_start = 1'b0;

      // Reset in layer 3 ISSUE of the back-to-back op, with a write in flight.
      run_to(1480);
      check("pre-reset wr_en", 32'(bus.o_wr_en), 32'd1);
      check("pre-reset rd_en", 32'(bus.o_rd_en), 32'd1);
      rst = 1'b1;
      #1;
      check_idle_outputs("mid-op reset");
      step();
      rst = 1'b0;
      step();
      check_idle_outputs("after reset");

      cyc         = 0;
      wr_cnt      = 0;
      bus.i_start = 1'b1;
      bus.i_intt  = 1'b0;
      step();
      bus.i_start = 1'b0;
      check_rd("rerun l0c0", 32'd0, 32'd128, 32'd1);
      run_to(198);
      check_rd("rerun l1c64", 32'd128, 32'd192, 32'd3);
      run_to(1064);
      check("rerun c1064 done", 32'(bus.o_done), 32'd0);
      run_to(1065);
      check("rerun done", 32'(bus.o_done), 32'd1);
      check("rerun write count", 32'(wr_cnt), 32'd1024);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
